nibble_loader: RTL
==================

# nibble_loader

Upstream feeder for the display register file / seven-segment multiplexer. Accepts one 32-bit word over a valid/ready handshake and serialises it into eight nibble writes on the `write`/`sel`/`num` bus the display top already consumes. Digit 0 (`in_data[3:0]`) goes first, and `sel` ascends 0→7. This gives the display a single-transaction load path in place of eight hand-driven writes.

## Interface
- `NUM_DIGITS`, 8: digits per word; must be a power of two ≥2.
- `DIGIT_W`, 4: bits per digit, matching `num` width.
- `WRITE_GAP`, 0: idle cycles inserted between consecutive writes (0–15).
- `clk`  in  1  system clock (100 MHz); all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset. Share it with the display register file.
- `in_valid`  in  1  `in_data` holds a word to load.
- `in_ready`  out  1  high when a word can be accepted.
- `in_data`  in  NUM_DIGITS*DIGIT_W  word to display; digit i is `in_data[i*DIGIT_W +: DIGIT_W]`.
- `write`  out  1  write strobe to the register file, one cycle per digit.
- `sel`  out  $clog2(NUM_DIGITS)  target digit index.
- `num`  out  DIGIT_W  digit value.
- `busy`  out  1  high from the accept cycle until `done`.
- `done`  out  1  single-cycle pulse after the final digit slot.

## Operation
- FSM states:
  - IDLE: `in_ready`=1. On `in_valid && in_ready`, latch `in_data` into the word register, set the digit counter to 0 and the gap counter to 0, then go to WRITE.
  - WRITE: drive `write`=1, `sel`=counter, `num`=digit[counter] for exactly one cycle.
    - If counter==NUM_DIGITS-1, go to FIN.
    - Else if WRITE_GAP>0, go to GAP.
    - Else increment the counter and stay in WRITE.
  - GAP: `write`=0. Hold for WRITE_GAP cycles, then increment the counter and return to WRITE.
  - FIN: `done`=1 for one cycle, then go to IDLE.
- `in_ready` = (state==IDLE). `busy` = (state != IDLE).
- `in_valid` while busy is ignored. No queuing: the upstream must hold the word until `in_ready`.
- `sel` and `num` hold their last driven values when `write`=0. Consumers qualify on `write` only.
- Counter arithmetic is unsigned and sized $clog2(NUM_DIGITS). The terminal compare prevents wrap.
- The word register is loaded only on handshake. A change on `in_data` after acceptance has no effect.
- Reset values: state IDLE, `write`=0, `sel`=0, `num`=0, `done`=0, `busy`=0, `in_ready`=1 (first cycle after rst deasserts). The word register, counters and shadow (if present) are cleared to 0.
- Reset mid-load: the load is aborted with no further writes and no `done`. Digits already written stay in the register file unless the same rst also clears it, which is the intended wiring.

## Timing
- Handshake at edge N. Digit i is written in cycle N+1+i*(WRITE_GAP+1).
- `done` asserts in the cycle after the digit-7 write. `in_ready` returns the cycle after `done`.
- Total load latency, accept to `done`: NUM_DIGITS*(WRITE_GAP+1)-WRITE_GAP+1 cycles. With WRITE_GAP=0 this is 9 cycles.
- Back-to-back loads: next accept is possible at the earliest one cycle after `done`.
- All outputs are registered except `in_ready` and `busy`, which decode from the state register.

## Configuration
- `NIBBLE_LOADER_SKIP_UNCHANGED_EN`:
  - Defined: a shadow register mirrors the last written value of every digit, cleared by rst. In a WRITE slot whose digit equals its shadow entry, `write` stays 0. The slot still consumes its cycle, so timing is identical to the undefined case. Shadow entries update only on actual writes.
  - Undefined: no shadow logic; every slot writes.

## Structure
- Package `nibble_loader_pkg`: state enum `loader_state_e` (IDLE, WRITE, GAP, FIN) and the default localparams for NUM_DIGITS and DIGIT_W.
- One sub-module, `gap_timer`: a loadable down-counter producing an `expired` flag for the GAP state.
- The digit mux and the optional shadow stay in the top-level block.

## Test plan
- Basic load: WRITE_GAP=0, handshake `32'h87654321` → `write`=1 for 8 consecutive cycles with (`sel`,`num`) = (0,1),(1,2)…(7,8); `done` in cycle 9; `in_ready` high in cycle 10.
- Backpressure: hold `in_valid`=1 with a new word during the load → `in_ready`=0 throughout. The second word is accepted exactly in the cycle after `done` and starts its writes one cycle later.
- Gap spacing: WRITE_GAP=2, word `32'hFFFF0000` → writes in cycles 1,4,7…22; `num`=0 for sel 0–3 and F for sel 4–7; `done` in cycle 23.
- Reset mid-load: assert rst for one cycle after the sel=2 write → no writes after that; `done` never pulses; all outputs at reset values; a new load afterwards starts again at sel=0.
- Skip unchanged (macro defined): load `32'h12345678` twice → first load gives 8 writes. The second gives 0 writes, but `done` still arrives 9 cycles after accept. A third load of `32'h12345679` gives exactly one write: sel=0, `num`=9.

Source files
------------

// File: rtl/nibble_loader_pkg.sv
// Shared types and default sizes for the nibble loader block.
package nibble_loader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        GAP   = 2'd2,
        FIN   = 2'd3
    } loader_state_e;

    localparam int NUM_DIGITS_DEF = 8;
    localparam int DIGIT_W_DEF    = 4;
    localparam int GAP_W          = 4;

endpackage

// File: rtl/gap_timer.sv
// Loadable down-counter that times the idle slots between digit writes.
// Latency: expired_o reflects the registered count (0 cycles after load when loaded with 0).
// Backpressure: none; load_i takes priority over dec_i, counting stops at zero.
module gap_timer
    import nibble_loader_pkg::*;
#(
    parameter int W = GAP_W
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         expired_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/nibble_loader.sv
// Serialises one accepted word into NUM_DIGITS ascending digit writes; optional NIBBLE_LOADER_SKIP_UNCHANGED_EN suppresses repeat writes.
// Latency: first write the cycle after accept, done NUM_DIGITS*(WRITE_GAP+1)-WRITE_GAP+1 cycles after accept.
// Backpressure: in_ready_o only in IDLE; in_valid_i is ignored while busy, upstream holds the word.
module nibble_loader
    import nibble_loader_pkg::*;
#(
    parameter int NUM_DIGITS = NUM_DIGITS_DEF,
    parameter int DIGIT_W    = DIGIT_W_DEF,
    parameter int WRITE_GAP  = 0
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          in_valid_i,
    output logic                          in_ready_o,
    input  logic [NUM_DIGITS*DIGIT_W-1:0] in_data_i,
    output logic                          write_o,
    output logic [$clog2(NUM_DIGITS)-1:0] sel_o,
    output logic [DIGIT_W-1:0]            num_o,
    output logic                          busy_o,
    output logic                          done_o
);

    localparam int SEL_W  = $clog2(NUM_DIGITS);
    localparam int WORD_W = NUM_DIGITS * DIGIT_W;
    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_DIGITS - 1);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((WRITE_GAP > 0) ? WRITE_GAP - 1 : 0);

    loader_state_e      state_q, state_d;
    logic [WORD_W-1:0]  word_q, word_d;
    logic [SEL_W-1:0]   cnt_q, cnt_d;
    logic               write_q, write_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [DIGIT_W-1:0] num_q, num_d;
    logic               done_q, done_d;

    logic               gap_load;
    logic [GAP_W-1:0]   gap_load_val;
    logic               gap_dec;
    logic               gap_expired;

    logic [DIGIT_W-1:0] digits [NUM_DIGITS];
    logic [DIGIT_W-1:0] digit_nxt;
    logic               slot_nxt;

    gap_timer #(
        .W (GAP_W)
    ) u_gap_timer (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (gap_load),
        .load_val_i (gap_load_val),
        .dec_i      (gap_dec),
        .expired_o  (gap_expired)
    );

    always_comb begin
        state_d      = state_q;
        word_d       = word_q;
        cnt_d        = cnt_q;
        gap_load     = 1'b0;
        gap_load_val = '0;
        gap_dec      = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid_i && in_ready_o) begin
                    word_d   = in_data_i;
                    cnt_d    = '0;
                    gap_load = 1'b1;
                    state_d  = WRITE;
                end
            end
            WRITE: begin
                if (cnt_q == LAST_SEL) begin
                    state_d = FIN;
                end else if (WRITE_GAP > 0) begin
                    gap_load     = 1'b1;
                    gap_load_val = GAP_LOAD;
                    state_d      = GAP;
                end else begin
                    cnt_d = cnt_q + SEL_W'(1);
                end
            end
            GAP: begin
                if (gap_expired) begin
                    cnt_d   = cnt_q + SEL_W'(1);
                    state_d = WRITE;
                end else begin
                    gap_dec = 1'b1;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are registered, so they are decoded from the next state and next word.
    always_comb begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
            digits[i] = word_d[i*DIGIT_W +: DIGIT_W];
        end
    end

    assign digit_nxt = digits[cnt_d];
    assign slot_nxt  = (state_d == WRITE);

`ifdef NIBBLE_LOADER_SKIP_UNCHANGED_EN
    logic [DIGIT_W-1:0] shadow_q [NUM_DIGITS];

    assign write_d = slot_nxt && (digit_nxt != shadow_q[cnt_d]);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                shadow_q[i] <= '0;
            end
        end else if (write_d) begin
            shadow_q[cnt_d] <= digit_nxt;
        end
    end
`else
    assign write_d = slot_nxt;
`endif

    assign sel_d  = write_d ? cnt_d : sel_q;
    assign num_d  = write_d ? digit_nxt : num_q;
    assign done_d = (state_d == FIN);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            word_q  <= '0;
            cnt_q   <= '0;
            write_q <= 1'b0;
            sel_q   <= '0;
            num_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            cnt_q   <= cnt_d;
            write_q <= write_d;
            sel_q   <= sel_d;
            num_q   <= num_d;
            done_q  <= done_d;
        end
    end

    assign in_ready_o = (state_q == IDLE);
    assign busy_o     = (state_q != IDLE);
    assign write_o    = write_q;
    assign sel_o      = sel_q;
    assign num_o      = num_q;
    assign done_o     = done_q;

endmodule
